ulpb_msg_sequencer: RTL

ULPB_MSG_SEQUENCER -- requirements
Module: ulpb_msg_sequencer

---
 rtl/ulpb_msg_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ulpb_msg_sequencer.sv
// ulpb_msg_sequencer: buffers a message, sends it word by word over the ULPB node TX handshake
// with retransmission on failure, and independently auto-acknowledges node RX requests.
module ulpb_msg_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WORDS = 8,
  parameter int RETRY_MAX = 3,
  parameter int CW = $clog2(MAX_WORDS + 1),
  parameter int RW = (RETRY_MAX < 4) ? 2 : $clog2(RETRY_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  clear,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] msg_addr,
  input  logic                  msg_prio,
  output logic [ADDR_WIDTH-1:0] TX_ADDR,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_REQ,
  output logic                  TX_PEND,
  output logic                  PRIORITY,
  input  logic                  TX_ACK,
  input  logic                  TX_SUCC,
  input  logic                  TX_FAIL,
  output logic                  TX_RESP_ACK,
  input  logic                  RX_REQ,
  input  logic                  RX_FAIL,
  output logic                  RX_ACK,
  input  logic [DATA_WIDTH-1:0] RX_DATA,
  output logic [CW-1:0]         word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  succ,
  output logic                  fail,
  output logic [RW-1:0]         retries,
  output logic [15:0]           rx_words,
  output logic [15:0]           rx_fails
);
  localparam int IW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [CW-1:0] WMAX = CW'(MAX_WORDS);
  localparam logic [RW-1:0] RMAX = RW'(RETRY_MAX);
  typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK, GAP, WAIT_RESP, RESP} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] mem [2**IW];
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CW-1:0] idx, last;
  logic prio_q, res_fail, sf, wr_ok;
  logic unused;
  assign unused = ^RX_DATA;
  assign sf = TX_SUCC | TX_FAIL;
  assign last = word_count - CW'(1);
  assign wr_ok = state == IDLE && !clear && wr_en && word_count != WMAX;
  always_ff @(posedge clk)
    if (wr_ok) mem[word_count[IW-1:0]] <= wr_data;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      TX_ADDR <= '0;
      TX_DATA <= '0;
      TX_REQ <= 1'b0;
      TX_PEND <= 1'b0;
      PRIORITY <= 1'b0;
      TX_RESP_ACK <= 1'b0;
      word_count <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      succ <= 1'b0;
      fail <= 1'b0;
      retries <= '0;
      addr_q <= '0;
      prio_q <= 1'b0;
      idx <= '0;
      res_fail <= 1'b0;
    end else begin
      done <= 1'b0;
      // a node result at any point of an active message aborts the remaining words
      if (state != IDLE && state != RESP && sf) begin
        TX_REQ <= 1'b0;
        TX_RESP_ACK <= 1'b1;
        res_fail <= TX_FAIL;
        state <= RESP;
      end else begin
        case (state)
          IDLE: begin
            if (clear) word_count <= '0;
            else if (start && word_count != '0) begin
              addr_q <= msg_addr;
              prio_q <= msg_prio;
              idx <= '0;
              retries <= '0;
              busy <= 1'b1;
              succ <= 1'b0;
              fail <= 1'b0;
              state <= SEND;
            end else if (wr_ok) word_count <= word_count + CW'(1);
          end
          SEND: if (!TX_ACK) begin
            TX_REQ <= 1'b1;
            TX_ADDR <= addr_q;
            TX_DATA <= mem[idx[IW-1:0]];
            TX_PEND <= idx != last;
            PRIORITY <= prio_q;
            state <= WAIT_ACK;
          end
          WAIT_ACK: if (TX_ACK) begin
            TX_REQ <= 1'b0;
            state <= GAP;
          end
          GAP: if (!TX_ACK) begin
            idx <= (idx == last) ? idx : idx + CW'(1);
            state <= (idx == last) ? WAIT_RESP : SEND;
          end
          WAIT_RESP: state <= WAIT_RESP;
          RESP: if (!sf) begin
            TX_RESP_ACK <= 1'b0;
            if (res_fail && retries < RMAX) begin
              retries <= retries + RW'(1);
              idx <= '0;
              state <= SEND;
            end else begin
              done <= 1'b1;
              busy <= 1'b0;
              word_count <= '0;
              succ <= !res_fail;
              fail <= res_fail;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      RX_ACK <= 1'b0;
      rx_words <= '0;
      rx_fails <= '0;
    end else if ((RX_REQ || RX_FAIL) && !RX_ACK) begin
      RX_ACK <= 1'b1;
      if (RX_REQ && rx_words != 16'hFFFF) rx_words <= rx_words + 16'd1;
      if (RX_FAIL && rx_fails != 16'hFFFF) rx_fails <= rx_fails + 16'd1;
    end else if (!RX_REQ && !RX_FAIL && RX_ACK) RX_ACK <= 1'b0;
  end
endmodule
